// File: rtl/peripheral_divider_n.sv
// Bus-mapped iterative integer divider: restoring shift-subtract, one quotient bit per clock,
// optional two's-complement mode with truncating (C-style) quotient and remainder.
module peripheral_divider_n #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [2:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);

    localparam int CW = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  dvd_r;
    logic [WIDTH-1:0]  dvs_r;
    logic [WIDTH-1:0]  quot_r;
    logic [WIDTH-1:0]  rem_r;
    logic              signed_r;
    logic              irq_en_r;
    logic              done_r;
    logic              dbz_r;

    logic [WIDTH-1:0]  op_dvd_r;
    logic [WIDTH-1:0]  op_dvs_r;
    logic              op_signed_r;
    logic              op_dbz_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  div_r;
    logic [CW-1:0]     cnt_r;

    logic              wr_s;
    logic              rd_s;
    logic              ctrl_wr_s;
    logic              start_s;
    logic              clr_s;
    logic              busy_s;
    logic              done_nx_s;
    logic              irq_en_nx_s;
    logic [WIDTH:0]    shift_s;
    logic              ge_s;
    logic              dvd_neg_s;
    logic              dvs_neg_s;
    logic              sx_s;
    logic [31:0]       rdata_s;

    function automatic logic [31:0] extend(input logic [WIDTH-1:0] v, input logic sx);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (sx) begin
            extend = 32'(sv);
        end else begin
            extend = 32'(v);
        end
    endfunction

    // Bus decode and next values of the flags feeding the registered irq
    always_comb begin
        wr_s      = cs & wr;
        rd_s      = cs & rd;
        ctrl_wr_s = wr_s && (addr == 3'd2);
        start_s   = ctrl_wr_s && d_in[0] && (state_r == ST_IDLE);
        clr_s     = wr_s && (addr == 3'd3) && d_in[0];
        busy_s    = (state_r != ST_IDLE);
        // Completion beats a same-edge clear so a finished result is never lost
        if (state_r == ST_DONE) begin
            done_nx_s = 1'b1;
        end else if (start_s || clr_s) begin
            done_nx_s = 1'b0;
        end else begin
            done_nx_s = done_r;
        end
        if (ctrl_wr_s) begin
            irq_en_nx_s = d_in[2];
        end else begin
            irq_en_nx_s = irq_en_r;
        end
    end

    // Datapath helpers: trial subtraction and operand signs
    always_comb begin
        shift_s   = {acc_r, q_r[WIDTH-1]};
        ge_s      = (shift_s >= {1'b0, div_r});
        dvd_neg_s = op_signed_r & op_dvd_r[WIDTH-1];
        dvs_neg_s = op_signed_r & op_dvs_r[WIDTH-1];
    end

    // Read data selection with per-register extension
    always_comb begin
        sx_s = signed_r & SIGNED_EN;
        case (addr)
            3'd0:    rdata_s = extend(dvd_r, 1'b0);
            3'd1:    rdata_s = extend(dvs_r, 1'b0);
            3'd3:    rdata_s = {29'd0, dbz_r, busy_s, done_r};
            3'd4:    rdata_s = extend(quot_r, sx_s);
            3'd5:    rdata_s = extend(rem_r, sx_s);
            default: rdata_s = 32'd0;
        endcase
    end

    // Register file, control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            quot_r      <= '0;
            rem_r       <= '0;
            signed_r    <= 1'b0;
            irq_en_r    <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            op_dvd_r    <= '0;
            op_dvs_r    <= '0;
            op_signed_r <= 1'b0;
            op_dbz_r    <= 1'b0;
            acc_r       <= '0;
            q_r         <= '0;
            div_r       <= '0;
            cnt_r       <= '0;
            d_out       <= 32'd0;
            irq         <= 1'b0;
        end else begin
            d_out    <= rd_s ? rdata_s : 32'd0;
            irq      <= done_nx_s & irq_en_nx_s;
            done_r   <= done_nx_s;
            irq_en_r <= irq_en_nx_s;
            if (wr_s && (addr == 3'd0)) begin
                dvd_r <= d_in[WIDTH-1:0];
            end
            if (wr_s && (addr == 3'd1)) begin
                dvs_r <= d_in[WIDTH-1:0];
            end
            if (ctrl_wr_s) begin
                signed_r <= d_in[1] & SIGNED_EN;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        op_dvd_r    <= dvd_r;
                        op_dvs_r    <= dvs_r;
                        op_signed_r <= d_in[1] & SIGNED_EN;
                        dbz_r       <= 1'b0;
                        state_r     <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    cnt_r <= '0;
                    // Zero divisor skips RUN; FIX passes the preset result through untouched
                    if (op_dvs_r == '0) begin
                        op_dbz_r <= 1'b1;
                        q_r      <= '1;
                        acc_r    <= op_dvd_r;
                        state_r  <= ST_FIX;
                    end else begin
                        op_dbz_r <= 1'b0;
                        acc_r    <= '0;
                        q_r      <= dvd_neg_s ? -op_dvd_r : op_dvd_r;
                        div_r    <= dvs_neg_s ? -op_dvs_r : op_dvs_r;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ge_s) begin
                        acc_r <= WIDTH'(shift_s - {1'b0, div_r});
                    end else begin
                        acc_r <= shift_s[WIDTH-1:0];
                    end
                    q_r   <= {q_r[WIDTH-2:0], ge_s};
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!op_dbz_r) begin
                        if (dvd_neg_s ^ dvs_neg_s) begin
                            q_r <= -q_r;
                        end
                        if (dvd_neg_s) begin
                            acc_r <= -acc_r;
                        end
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    quot_r  <= q_r;
                    rem_r   <= acc_r;
                    dbz_r   <= op_dbz_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
